// File: rtl/hero_sprite_fetch.sv
// Hero sprite pixel fetch: bounding-box test, sprite-ROM addressing with
// animation frame and mirroring, and a 3-cycle aligned palette-index output.
module hero_sprite_fetch #(
   parameter int SPR_W      = 32,
   parameter int SPR_H      = 48,
   parameter int FRAMES     = 4,
   parameter int ANIM_DIV   = 8,
   parameter int IDX_W      = 3,
   parameter int TRANSP_IDX = 0,
   parameter int ADDR_W     = 13
) (
   input  logic                       vga_clk_i,
   input  logic                       Reset_i,
   input  logic [9:0]                 DrawX_i,
   input  logic [9:0]                 DrawY_i,
   input  logic                       blank_i,
   input  logic                       frame_start_i,
   input  logic                       enable_i,
   input  logic [9:0]                 hero_x_i,
   input  logic [9:0]                 hero_y_i,
   input  logic                       facing_left_i,
   output logic [ADDR_W-1:0]          rom_addr_o,
   input  logic [IDX_W-1:0]           rom_q_i,
   output logic [IDX_W-1:0]           pal_index_o,
   output logic                       pix_valid_o,
   output logic [$clog2(FRAMES)-1:0]  anim_frame_o
);

   localparam int AF_W  = $clog2(FRAMES);
   localparam int DIV_W = $clog2(ANIM_DIV + 1);

   logic [9:0]        hx_q, hy_q;
   logic              mir_q, en_q;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [AF_W-1:0]   anim_q, anim_d;
   logic [ADDR_W-1:0] rom_addr_q, addr_d;
   logic              inside_d1_q, inside_d2_q, inside_d;
   logic [IDX_W-1:0]  pal_q;
   logic              vld_q;
   logic [10:0]       x11, y11, hx11, hy11, dx, dy, col;

   // Animation stepping counts pulses that carry enable=1, so the first pulse
   // after enabling already counts toward the first step.
   always_comb begin
      div_d  = div_q;
      anim_d = anim_q;
      if (frame_start_i) begin
         if (!enable_i) begin
            div_d  = '0;
            anim_d = '0;
         end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
            div_d  = '0;
            anim_d = (anim_q == AF_W'(FRAMES - 1)) ? '0 : anim_q + AF_W'(1);
         end else begin
            div_d  = div_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge vga_clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         hx_q   <= '0;
         hy_q   <= '0;
         mir_q  <= 1'b0;
         en_q   <= 1'b0;
         div_q  <= '0;
         anim_q <= '0;
      end else begin
         div_q  <= div_d;
         anim_q <= anim_d;
         if (frame_start_i) begin
            hx_q  <= hero_x_i;
            hy_q  <= hero_y_i;
            mir_q <= facing_left_i;
            en_q  <= enable_i;
         end
      end
   end

   // 11-bit arithmetic keeps hx+SPR_W past column 639 from wrapping.
   always_comb begin
      x11      = {1'b0, DrawX_i};
      y11      = {1'b0, DrawY_i};
      hx11     = {1'b0, hx_q};
      hy11     = {1'b0, hy_q};
      dx       = x11 - hx11;
      dy       = y11 - hy11;
      col      = mir_q ? (11'(SPR_W - 1) - dx) : dx;
      inside_d = en_q & blank_i
               & (x11 >= hx11) & (x11 < hx11 + 11'(SPR_W))
               & (y11 >= hy11) & (y11 < hy11 + 11'(SPR_H));
      addr_d   = '0;
      if (inside_d)
         addr_d = ADDR_W'(anim_q) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(dy) * ADDR_W'(SPR_W)
                + ADDR_W'(col);
   end

   always_ff @(posedge vga_clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         rom_addr_q  <= '0;
         inside_d1_q <= 1'b0;
         inside_d2_q <= 1'b0;
         pal_q       <= '0;
         vld_q       <= 1'b0;
      end else begin
         rom_addr_q  <= addr_d;
         inside_d1_q <= inside_d;
         inside_d2_q <= inside_d1_q;
         pal_q       <= inside_d2_q ? rom_q_i : IDX_W'(TRANSP_IDX);
         vld_q       <= inside_d2_q & (rom_q_i != IDX_W'(TRANSP_IDX));
      end
   end

   assign rom_addr_o   = rom_addr_q;
   assign pal_index_o  = pal_q;
   assign pix_valid_o  = vld_q;
   assign anim_frame_o = anim_q;

endmodule

// File: tb/tb_hero_sprite_fetch.sv
// Scoreboard bench for hero_sprite_fetch: directed pixels push expected
// rom_addr and output values; a negedge monitor pops and compares.
module tb_hero_sprite_fetch;

   logic        clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY, hero_x, hero_y;
   logic        blank, frame_start, enable, facing_left;
   logic [12:0] rom_addr;
   logic [2:0]  rom_q, pal_index;
   logic        pix_valid;
   logic [1:0]  anim_frame;

   int n_checks = 0;
   int n_pass   = 0;
   int p        = 0;
   int addr_q[$];
   int pal_q[$];
   int vld_q[$];
   logic       cur_tag;
   logic [2:0] tag_pipe;

   always #5 clk = ~clk;

   hero_sprite_fetch dut (
      .vga_clk_i(clk), .Reset_i(Reset), .DrawX_i(DrawX), .DrawY_i(DrawY),
      .blank_i(blank), .frame_start_i(frame_start), .enable_i(enable),
      .hero_x_i(hero_x), .hero_y_i(hero_y), .facing_left_i(facing_left),
      .rom_addr_o(rom_addr), .rom_q_i(rom_q), .pal_index_o(pal_index),
      .pix_valid_o(pix_valid), .anim_frame_o(anim_frame)
   );

   // ROM content: data = low 3 address bits (so address 325 holds 5).
   always @(posedge clk) rom_q <= rom_addr[2:0];

   always @(posedge clk or posedge Reset)
      if (Reset) tag_pipe <= '0;
      else       tag_pipe <= {tag_pipe[1:0], cur_tag};

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (tag_pipe[0]) begin
         if (addr_q.size() == 0) chk("addr_queue_underflow", 1, 0);
         else chk("rom_addr", int'(rom_addr), addr_q.pop_front());
      end else chk("rom_addr_idle", int'(rom_addr), 0);
      if (tag_pipe[2]) begin
         if (pal_q.size() == 0) chk("out_queue_underflow", 1, 0);
         else begin
            chk("pal_index", int'(pal_index), pal_q.pop_front());
            chk("pix_valid", int'(pix_valid), vld_q.pop_front());
         end
      end else begin
         chk("pal_index_idle", int'(pal_index), 0);
         chk("pix_valid_idle", int'(pix_valid), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      blank = 1'b0; frame_start = 1'b0; cur_tag = 1'b0;
      DrawX = '0; DrawY = '0;
      repeat (n) tick();
   endtask

   task automatic pixel(input int x, input int y, input bit b,
                        input int ea, input int ep, input int ev);
      DrawX = 10'(x); DrawY = 10'(y); blank = b; frame_start = 1'b0;
      cur_tag = 1'b1;
      addr_q.push_back(ea); pal_q.push_back(ep); vld_q.push_back(ev);
      tick();
   endtask

   task automatic pulse(input int x, input int y, input bit left,
                        input bit en, input int exp_anim);
      blank = 1'b0; cur_tag = 1'b0; DrawX = '0; DrawY = '0;
      hero_x = 10'(x); hero_y = 10'(y); facing_left = left; enable = en;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("anim_frame", int'(anim_frame), exp_anim);
   endtask

   initial begin
      Reset = 1'b1; cur_tag = 1'b0;
      DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
      enable = 1'b0; hero_x = '0; hero_y = '0; facing_left = 1'b0;
      repeat (3) tick();
      chk("reset_anim", int'(anim_frame), 0);
      Reset = 1'b0;
      idle(2);

      // Basic address, latency, transparency and box edges
      p = 1; pulse(100, 200, 0, 1, 0);
      pixel(105, 210, 1, 325, 5, 1);
      pixel(108, 210, 1, 328, 0, 0);
      pixel( 99, 210, 1,   0, 0, 0);
      pixel(132, 210, 1,   0, 0, 0);
      pixel(131, 210, 1, 351, 7, 1);
      pixel(101, 247, 1, 1505, 1, 1);
      pixel(101, 248, 1,   0, 0, 0);
      pixel(105, 210, 0,   0, 0, 0);
      idle(4);

      // Position latch: a change without frame_start is ignored
      hero_x = 10'd300;
      pixel(105, 210, 1, 325, 5, 1);
      pixel(305, 210, 1,   0, 0, 0);
      idle(4);

      // Animation: step every 8 pulses
      for (int k = 2; k <= 16; k++) begin
         p = k; pulse(100, 200, 0, 1, (p / 8) % 4);
      end

      // Mirror at frame 2
      p = 17; pulse(100, 200, 1, 1, 2);
      pixel(105, 210, 1, 3418, 2, 1);
      pixel(100, 210, 1, 3423, 7, 1);
      idle(4);

      // Right-edge clipping, no wrap to small x
      p = 18; pulse(630, 200, 0, 1, 2);
      pixel(639, 200, 1, 3081, 1, 1);
      pixel(630, 200, 1, 3072, 0, 0);
      pixel(  5, 200, 1,    0, 0, 0);
      idle(4);

      // Wrap after 32 pulses, then leave divider mid-count
      for (int k = 19; k <= 43; k++) begin
         p = k; pulse(100, 200, 0, 1, (p / 8) % 4);
      end

      // Disable clears frame and divider
      p = 0; pulse(100, 200, 0, 0, 0);
      pixel(105, 210, 1, 0, 0, 0);
      idle(4);
      for (int k = 1; k <= 8; k++) begin
         p = k; pulse(100, 200, 0, 1, (p / 8) % 4);
      end

      // Mid-frame reset while sweeping through the box
      idle(4);
      Reset = 1'b1; blank = 1'b1; DrawY = 10'd210;
      for (int x = 100; x < 112; x++) begin
         DrawX = 10'(x);
         tick();
      end
      chk("reset_anim_mid", int'(anim_frame), 0);
      Reset = 1'b0;
      tick();
      idle(2);
      p = 1; pulse(100, 200, 0, 1, 0);
      pixel(105, 210, 1, 325, 5, 1);
      idle(6);

      chk("queues_drained", addr_q.size() + pal_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hero_sprite_fetch.md
Name: hero_sprite_fetch

Overview:
- Upstream pixel-fetch stage for the hero sprite path. It feeds the 3-bit palette index into the hero palette lookup, which maps it to 12-bit RGB.
- Per VGA pixel it decides whether the pixel lies inside the hero's bounding box and builds the sprite-ROM address, including animation frame and horizontal mirroring.
- It returns the ROM's palette index with an opaque/transparent valid flag, pipeline-aligned to the pixel coordinate.
- It owns the idle-animation frame counter, stepped by frame-start pulses.

Parameters:
- SPR_W, 32, sprite width in pixels.
- SPR_H, 48, sprite height in pixels.
- FRAMES, 4, animation frames stored back-to-back in ROM.
- ANIM_DIV, 8, number of frame_start pulses per animation step.
- IDX_W, 3, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent (chroma key).
- ADDR_W, 13, ROM address width. Must satisfy 2^ADDR_W >= FRAMES*SPR_W*SPR_H.

Ports:
- vga_clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column, 0..639.
- DrawY  in  10  current pixel row, 0..479.
- blank  in  1  1 = active video, 0 = blanking.
- frame_start  in  1  one-cycle pulse, once per frame, during vertical blanking.
- enable  in  1  hero visible/animating.
- hero_x  in  10  sprite left edge (screen coords).
- hero_y  in  10  sprite top edge.
- facing_left  in  1  mirror sprite horizontally.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  IDX_W  ROM data; synchronous ROM, valid 1 cycle after rom_addr.
- pal_index  out  IDX_W  palette index to the palette block.
- pix_valid  out  1  pixel inside sprite, visible and non-transparent.
- anim_frame  out  2  current animation frame (clog2(FRAMES) bits).

Behaviour:
- Reset (async, high): all registers 0, so rom_addr=0, pal_index=0, pix_valid=0, anim_frame=0. Latched position, mirror flag and divider counter are 0. Applies mid-frame; output stays invalid until Reset is deasserted and the pipeline refills.
- Position latch: on the cycle frame_start=1, hx<=hero_x, hy<=hero_y, mir<=facing_left, en_l<=enable. The latched values apply from the next cycle. Input changes between pulses are ignored (no tearing).
- Animation:
  - div counts frame_start pulses 0..ANIM_DIV-1 while en_l=1. On a pulse with div=ANIM_DIV-1, div<=0 and anim_frame<=(anim_frame+1) mod FRAMES.
  - A frame_start pulse with enable=0 clears div and anim_frame to 0.
- Stage 0 (combinational on inputs at cycle N):
  - dx=DrawX-hx, dy=DrawY-hy, computed 11-bit.
  - inside = en_l & blank & DrawX>=hx & DrawX<hx+SPR_W & DrawY>=hy & DrawY<hy+SPR_H. Sums are 11-bit, so hx+SPR_W>639 clips correctly without wrap.
  - col = mir ? SPR_W-1-dx : dx.
  - addr = anim_frame*SPR_W*SPR_H + dy*SPR_W + col, truncated to ADDR_W. Don't-care when inside=0; register 0 in that case.
- Cycle N+1: rom_addr and inside_d1 registered.
- Cycle N+2: rom_q valid; inside_d2 registered.
- Cycle N+3 (registered outputs):
  - pal_index <= inside_d2 ? rom_q : TRANSP_IDX.
  - pix_valid <= inside_d2 & (rom_q != TRANSP_IDX).
- Total latency: DrawX/DrawY at N → pal_index/pix_valid at N+3. Downstream delays its coordinates by 3.
- Throughput: one pixel per clock, no stalls.
- anim_frame change on frame_start: pixels still in the pipeline come from blanking, so no mixed-frame output is possible.
- Width rules:
  - dy*SPR_W and frame offset are formed with full ADDR_W width before the add.
  - dx and dy stay non-negative whenever inside=1.

Test Plan:
- Reset: hold Reset=1 mid-line with DrawX sweeping → rom_addr=0, pix_valid=0, pal_index=0 every cycle. After release, first valid output appears exactly 3 cycles after the first inside pixel.
- Address/latency: hero_x=100, hero_y=200, enable=1, anim_frame=0, pulse frame_start, drive DrawX=105, DrawY=210 → rom_addr=10*32+5=325 at N+1. ROM model returns 5 → pal_index=5, pix_valid=1 at N+3.
- Mirror + frame: facing_left=1, anim_frame=2, same pixel → rom_addr=2*1536+320+26=3418.
- Transparency/edges:
  - ROM returns 0 inside the box → pix_valid=0.
  - DrawX=99 and DrawX=132 → pix_valid=0.
  - DrawX=131 → candidate, valid if ROM returns nonzero.
  - hero_x=630 → columns 630..639 fetched, no wrap to x<10.
- Animation: enable=1, issue 8 frame_start pulses → anim_frame 0→1. After 32 pulses it wraps to 0. A pulse with enable=0 → anim_frame=0, div=0.
- Position latch: change hero_x from 100 to 300 mid-frame without frame_start → the box stays at 100 until the next pulse.
